// File: rtl/oled_text_scheduler.sv
// oled_text_scheduler: round-robin arbiter between the status message and the
// error count, streaming each 3-char string as a 24x8 RGB565 window.
module oled_text_scheduler #(
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h0000,
    parameter logic [6:0]  MSG_COL  = 7'd0,
    parameter logic [5:0]  MSG_ROW  = 6'd0,
    parameter logic [6:0]  CNT_COL  = 7'd0,
    parameter logic [5:0]  CNT_ROW  = 6'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_req,
    input  logic        msg_sel,
    input  logic        cnt_req,
    input  logic [9:0]  cnt_val,
    output logic        msg_ack,
    output logic        cnt_ack,
    output logic        busy,
    output logic [3:0]  glyph_code,
    output logic [2:0]  glyph_row,
    input  logic [7:0]  glyph_bits,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [6:0]  win_col,
    output logic [5:0]  win_row,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [15:0] pix_data,
    output logic        pix_last,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_WIN,
        S_PIX,
        S_DONE
    } state_t;

    localparam logic [3:0] CH_G  = 4'd10;
    localparam logic [3:0] CH_O  = 4'd11;
    localparam logic [3:0] CH_SP = 4'd12;
    localparam logic [3:0] CH_E  = 4'd13;
    localparam logic [3:0] CH_R  = 4'd14;
    localparam logic [3:0] CH_S  = 4'd15;

    state_t      state;
    logic        rr_cnt;
    logic        grant_msg;
    logic        grant_cnt;
    logic [9:0]  cnt_sat;
    logic [9:0]  bin_q;
    logic [10:0] bcd_q;
    logic [11:0] bcd_next;
    logic [3:0]  units_adj;
    logic [3:0]  tens_adj;
    logic [3:0]  conv_cnt;
    logic [3:0]  dig_h;
    logic [3:0]  dig_t;
    logic [3:0]  dig_u;
    logic [3:0]  ch0;
    logic [3:0]  ch1;
    logic [3:0]  ch2;
    logic [3:0]  cur_code;
    logic [2:0]  row_q;
    logic [1:0]  chr_q;
    logic [2:0]  col_q;
    logic        last_pix;

    assign cnt_sat = (cnt_val > 10'd999) ? 10'd999 : cnt_val;

    // Acceptance: lone request wins, otherwise the side not served last.
    always_comb begin
        grant_msg = 1'b0;
        grant_cnt = 1'b0;
        if (state == S_IDLE && !rst) begin
            if (msg_req && (!cnt_req || !rr_cnt)) begin
                grant_msg = 1'b1;
            end else if (cnt_req) begin
                grant_cnt = 1'b1;
            end
        end
    end

    assign msg_ack = grant_msg;
    assign cnt_ack = grant_cnt;

    // One double-dabble step; hundreds stays below 5 before its final shift.
    always_comb begin
        units_adj = bcd_q[3:0];
        tens_adj  = bcd_q[7:4];
        if (bcd_q[3:0] >= 4'd5) begin
            units_adj = bcd_q[3:0] + 4'd3;
        end
        if (bcd_q[7:4] >= 4'd5) begin
            tens_adj = bcd_q[7:4] + 4'd3;
        end
        bcd_next = {bcd_q[10:8], tens_adj, units_adj, bin_q[9]};
    end

    assign dig_h = bcd_next[11:8];
    assign dig_t = bcd_next[7:4];
    assign dig_u = bcd_next[3:0];

    // Character of the column group currently being streamed.
    always_comb begin
        cur_code = ch0;
        if (chr_q == 2'd1) begin
            cur_code = ch1;
        end else if (chr_q == 2'd2) begin
            cur_code = ch2;
        end
    end

    assign last_pix   = (row_q == 3'd7) && (chr_q == 2'd2) && (col_q == 3'd7);
    assign glyph_code = pix_valid ? cur_code : 4'd0;
    assign glyph_row  = pix_valid ? row_q : 3'd0;
    assign pix_last   = pix_valid && last_pix;
    assign pix_data   = !pix_valid ? 16'd0 :
                        (glyph_bits[col_q] ? FG_COLOR : BG_COLOR);

    // Main sequencer: arbitration, conversion, window and pixel streaming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_cnt    <= 1'b0;
            busy      <= 1'b0;
            win_valid <= 1'b0;
            pix_valid <= 1'b0;
            done      <= 1'b0;
            win_col   <= 7'd0;
            win_row   <= 6'd0;
            bin_q     <= 10'd0;
            bcd_q     <= 11'd0;
            conv_cnt  <= 4'd0;
            ch0       <= 4'd0;
            ch1       <= 4'd0;
            ch2       <= 4'd0;
            row_q     <= 3'd0;
            chr_q     <= 2'd0;
            col_q     <= 3'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant_msg) begin
                        ch0       <= msg_sel ? CH_E : CH_G;
                        ch1       <= msg_sel ? CH_R : CH_O;
                        ch2       <= msg_sel ? CH_S : CH_SP;
                        win_col   <= MSG_COL;
                        win_row   <= MSG_ROW;
                        rr_cnt    <= 1'b1;
                        busy      <= 1'b1;
                        win_valid <= 1'b1;
                        state     <= S_WIN;
                    end else if (grant_cnt) begin
                        bin_q    <= cnt_sat;
                        bcd_q    <= 11'd0;
                        conv_cnt <= 4'd0;
                        win_col  <= CNT_COL;
                        win_row  <= CNT_ROW;
                        rr_cnt   <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    bin_q    <= {bin_q[8:0], 1'b0};
                    bcd_q    <= bcd_next[10:0];
                    conv_cnt <= conv_cnt + 4'd1;
                    if (conv_cnt == 4'd9) begin
                        ch0 <= (dig_h == 4'd0) ? CH_SP : dig_h;
                        ch1 <= (dig_h == 4'd0 && dig_t == 4'd0) ? CH_SP : dig_t;
                        ch2 <= dig_u;
                        win_valid <= 1'b1;
                        state     <= S_WIN;
                    end
                end
                S_WIN: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        pix_valid <= 1'b1;
                        row_q     <= 3'd0;
                        chr_q     <= 2'd0;
                        col_q     <= 3'd0;
                        state     <= S_PIX;
                    end
                end
                S_PIX: begin
                    if (pix_ready) begin
                        if (col_q != 3'd7) begin
                            col_q <= col_q + 3'd1;
                        end else begin
                            col_q <= 3'd0;
                            if (chr_q != 2'd2) begin
                                chr_q <= chr_q + 2'd1;
                            end else begin
                                chr_q <= 2'd0;
                                row_q <= row_q + 3'd1;
                            end
                        end
                        if (last_pix) begin
                            pix_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_text_scheduler.sv
// tb_oled_text_scheduler: directed scenarios for the OLED text scheduler
// with a small font ROM and a row-major pixel reference.
module tb_oled_text_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_req;
    logic        msg_sel;
    logic        cnt_req;
    logic [9:0]  cnt_val;
    logic        msg_ack;
    logic        cnt_ack;
    logic        busy;
    logic [3:0]  glyph_code;
    logic [2:0]  glyph_row;
    logic [7:0]  glyph_bits;
    logic        win_valid;
    logic        win_ready;
    logic [6:0]  win_col;
    logic [5:0]  win_row;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        pix_last;
    logic        done;

    int checks = 0;
    int passed = 0;

    oled_text_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .msg_req    (msg_req),
        .msg_sel    (msg_sel),
        .cnt_req    (cnt_req),
        .cnt_val    (cnt_val),
        .msg_ack    (msg_ack),
        .cnt_ack    (cnt_ack),
        .busy       (busy),
        .glyph_code (glyph_code),
        .glyph_row  (glyph_row),
        .glyph_bits (glyph_bits),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_col    (win_col),
        .win_row    (win_row),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Font ROM stand-in: space blank, G row 0 = 3C, others a fixed pattern.
    function automatic logic [7:0] font(input logic [3:0] c, input logic [2:0] r);
        logic [7:0] v;
        if (c == 4'd12) v = 8'h00;
        else if (c == 4'd10 && r == 3'd0) v = 8'h3C;
        else v = {c, 1'b0, r} ^ {r, 1'b1, c};
        return v;
    endfunction

    assign glyph_bits = font(glyph_code, glyph_row);

    function automatic logic [42:0] outs();
        return {msg_ack, cnt_ack, busy, win_valid, win_col, win_row, pix_valid,
                pix_data, pix_last, done, glyph_code, glyph_row};
    endfunction

    function automatic logic rdy(input int pct);
        if (pct == 0) return 1'b1;
        return ($urandom_range(99) >= pct);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_draw(input string nm, input bit is_cnt, input logic sel,
                            input logic [9:0] val, input logic [3:0] e0,
                            input logic [3:0] e1, input logic [3:0] e2,
                            input int stall, input int abort_at);
        int k;
        int lat;
        int idx;
        int ncyc;
        int r;
        int c;
        int col;
        logic [3:0] ec;
        logic [7:0] bits;
        logic [15:0] ed;
        logic [6:0] ecol;
        logic [5:0] erow;
        ecol = 7'd0;
        erow = is_cnt ? 6'd16 : 6'd0;
        tick();
        if (is_cnt) begin
            cnt_req = 1'b1;
            cnt_val = val;
        end else begin
            msg_req = 1'b1;
            msg_sel = sel;
        end
        win_ready = 1'b0;
        pix_ready = 1'b0;
        @(negedge clk);
        k = 0;
        while (!(is_cnt ? cnt_ack : msg_ack) && k < 40) begin
            tick();
            @(negedge clk);
            k++;
        end
        checks++;
        if ({msg_ack, cnt_ack} !== (is_cnt ? 2'b01 : 2'b10))
            $display("FAIL %s ack: got %b want %b", nm, {msg_ack, cnt_ack},
                     is_cnt ? 2'b01 : 2'b10);
        else passed++;
        tick();
        msg_req = 1'b0;
        cnt_req = 1'b0;
        msg_sel = ~msg_sel;
        cnt_val = ~cnt_val;
        win_ready = rdy(stall);
        @(negedge clk);
        lat = 1;
        while (!win_valid && lat < 40) begin
            tick();
            win_ready = rdy(stall);
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != (is_cnt ? 11 : 1))
            $display("FAIL %s win latency: got %0d want %0d", nm, lat, is_cnt ? 11 : 1);
        else passed++;
        checks++;
        if ({win_valid, win_col, win_row} !== {1'b1, ecol, erow})
            $display("FAIL %s window: got v%b c%0d r%0d want v1 c%0d r%0d", nm,
                     win_valid, win_col, win_row, ecol, erow);
        else passed++;
        k = 0;
        while (!win_ready && k < 200) begin
            tick();
            win_ready = rdy(stall);
            @(negedge clk);
            k++;
            checks++;
            if ({win_valid, win_col, win_row} !== {1'b1, ecol, erow})
                $display("FAIL %s window stall: got v%b c%0d r%0d", nm,
                         win_valid, win_col, win_row);
            else passed++;
        end
        tick();
        win_ready = 1'b0;
        pix_ready = rdy(stall);
        @(negedge clk);
        checks++;
        if ({pix_valid, win_valid} !== 2'b10)
            $display("FAIL %s first pixel: got pv%b wv%b want pv1 wv0", nm,
                     pix_valid, win_valid);
        else passed++;
        idx = 0;
        ncyc = 0;
        while (idx < 192 && ncyc < 2000) begin
            if (abort_at >= 0 && idx == abort_at) break;
            r = idx / 24;
            c = (idx % 24) / 8;
            col = idx % 8;
            ec = (c == 0) ? e0 : ((c == 1) ? e1 : e2);
            bits = font(ec, r[2:0]);
            ed = bits[col] ? 16'hFFFF : 16'h0000;
            checks++;
            if ({pix_valid, pix_data, glyph_code, glyph_row, pix_last} !==
                {1'b1, ed, ec, r[2:0], (idx == 191)})
                $display("FAIL %s pixel %0d: got v%b d%h g%0d r%0d l%b want v1 d%h g%0d r%0d l%b",
                         nm, idx, pix_valid, pix_data, glyph_code, glyph_row, pix_last,
                         ed, ec, r[2:0], (idx == 191));
            else passed++;
            if (pix_valid && pix_ready) idx++;
            tick();
            pix_ready = rdy(stall);
            @(negedge clk);
            ncyc++;
        end
        if (abort_at >= 0) begin
            tick();
            rst = 1'b1;
            @(negedge clk);
            checks++;
            if (outs() !== 43'd0)
                $display("FAIL %s reset mid-draw: got %h want 0", nm, outs());
            else passed++;
            tick();
            rst = 1'b0;
            pix_ready = 1'b0;
            return;
        end
        checks++;
        if (idx != 192)
            $display("FAIL %s pixel count: got %0d want 192", nm, idx);
        else passed++;
        if (stall == 0) begin
            checks++;
            if (ncyc != 192)
                $display("FAIL %s pixel cycles: got %0d want 192", nm, ncyc);
            else passed++;
        end
        checks++;
        if ({done, pix_valid, busy} !== 3'b101)
            $display("FAIL %s done: got d%b pv%b b%b want d1 pv0 b1", nm,
                     done, pix_valid, busy);
        else passed++;
        pix_ready = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00)
            $display("FAIL %s idle after done: got d%b b%b want 0 0", nm, done, busy);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        msg_req = 1'b1;
        msg_sel = 1'b0;
        cnt_req = 1'b1;
        cnt_val = 10'd0;
        win_ready = 1'b0;
        pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs() !== 43'd0)
            $display("FAIL reset outputs: got %h want 0", outs());
        else passed++;
        msg_req = 1'b0;
        cnt_req = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (outs() !== 43'd0)
            $display("FAIL idle outputs: got %h want 0", outs());
        else passed++;
    endtask

    task automatic test_msg();
        run_draw("go", 1'b0, 1'b0, 10'd0, 4'd10, 4'd11, 4'd12, 0, -1);
        run_draw("ers", 1'b0, 1'b1, 10'd0, 4'd13, 4'd14, 4'd15, 0, -1);
    endtask

    task automatic test_count();
        run_draw("cnt42", 1'b1, 1'b0, 10'd42, 4'd12, 4'd4, 4'd2, 0, -1);
        run_draw("cnt0", 1'b1, 1'b0, 10'd0, 4'd12, 4'd12, 4'd0, 0, -1);
        run_draw("cnt1023", 1'b1, 1'b0, 10'd1023, 4'd9, 4'd9, 4'd9, 0, -1);
        run_draw("cnt100", 1'b1, 1'b0, 10'd100, 4'd1, 4'd0, 4'd0, 0, -1);
        run_draw("cnt7", 1'b1, 1'b0, 10'd7, 4'd12, 4'd12, 4'd7, 0, -1);
        run_draw("cnt999", 1'b1, 1'b0, 10'd999, 4'd9, 4'd9, 4'd9, 0, -1);
    endtask

    task automatic test_back_to_back();
        int k;
        logic [1:0] want;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        msg_req = 1'b1;
        msg_sel = 1'b0;
        cnt_req = 1'b1;
        cnt_val = 10'd5;
        win_ready = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            if (n > 0) begin
                k = 0;
                while (!done && k < 400) begin
                    tick();
                    @(negedge clk);
                    k++;
                end
                checks++;
                if (done !== 1'b1)
                    $display("FAIL rr done %0d: got %b want 1", n, done);
                else passed++;
                tick();
                @(negedge clk);
            end
            want = n[0] ? 2'b01 : 2'b10;
            checks++;
            if ({msg_ack, cnt_ack} !== want)
                $display("FAIL rr order %0d: got %b want %b", n, {msg_ack, cnt_ack}, want);
            else passed++;
            tick();
            if (n == 3) begin
                msg_req = 1'b0;
                cnt_req = 1'b0;
            end
            @(negedge clk);
        end
        k = 0;
        while (busy && k < 400) begin
            tick();
            @(negedge clk);
            k++;
        end
        checks++;
        if (busy !== 1'b0)
            $display("FAIL rr drain: got busy %b want 0", busy);
        else passed++;
    endtask

    task automatic test_stalls();
        run_draw("ers_stall", 1'b0, 1'b1, 10'd0, 4'd13, 4'd14, 4'd15, 50, -1);
        run_draw("cnt305_stall", 1'b1, 1'b0, 10'd305, 4'd3, 4'd0, 4'd5, 50, -1);
        run_draw("go_stall", 1'b0, 1'b0, 10'd0, 4'd10, 4'd11, 4'd12, 50, -1);
    endtask

    task automatic test_reset_mid();
        run_draw("ers_abort", 1'b0, 1'b1, 10'd0, 4'd13, 4'd14, 4'd15, 0, 100);
        run_draw("go_after_rst", 1'b0, 1'b0, 10'd0, 4'd10, 4'd11, 4'd12, 0, -1);
    endtask

    initial begin
        test_reset();
        test_msg();
        test_count();
        test_back_to_back();
        test_stalls();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/oled_text_scheduler.md
# oled_text_scheduler

Arbitrates between two text requesters, the status message ("GO " / "ERS") and the decimal error count, and streams the chosen 3-character string to the OLED RGB panel driver. Each string is drawn as a 24x8 pixel window of 16-bit colour. The block converts the error count to BCD, sequences glyph lookups in the 8x8 font ROM row by row, and hands out one window command followed by 192 pixels over valid/ready handshakes. It sits between the tester status logic and the OLED driver.

## Interface
- FG_COLOR, 16'hFFFF, colour of set glyph bits
- BG_COLOR, 16'h0000, colour of clear glyph bits
- MSG_COL / MSG_ROW, 0 / 0, window origin of status message (col 0-72, row 0-56)
- CNT_COL / CNT_ROW, 0 / 16, window origin of error count
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- msg_req  in  1  level request to draw status message; held until msg_ack
- msg_sel  in  1  0 = "GO ", 1 = "ERS"; sampled on msg_ack cycle
- cnt_req  in  1  level request to draw error count; held until cnt_ack
- cnt_val  in  10  binary error count; sampled on cnt_ack cycle
- msg_ack / cnt_ack  out  1  one-cycle acceptance pulse
- busy  out  1  high from cycle after ack through DONE
- glyph_code  out  4  font index: 0-9 digits, 10 G, 11 O, 12 space, 13 E, 14 R, 15 S
- glyph_row  out  3  font row 0-7 (0 = top)
- glyph_bits  in  8  combinational font ROM data; bit k = pixel column k (bit 0 leftmost)
- win_valid  out  1  window command valid
- win_ready  in  1  driver accepts window command
- win_col  out  7  window start column; width fixed at 24
- win_row  out  6  window start row; height fixed at 8
- pix_valid  out  1  pixel valid
- pix_ready  in  1  driver accepts pixel
- pix_data  out  16  RGB565 pixel
- pix_last  out  1  marks pixel 191 of the window
- done  out  1  one-cycle pulse after the last pixel transfers

## Operation
- States: IDLE, CONV, WIN, PIX, DONE.
- IDLE: if only one request is pending, accept it. If both are pending, accept the one not served last (round-robin). After reset the message has priority. On acceptance, pulse that ack, latch msg_sel or cnt_val, and update the round-robin pointer.
- Message accepted: go to WIN with characters {G,O,space} or {E,R,S}.
- Count accepted: go to CONV. Values >999 saturate to 999.
- CONV: double-dabble, one input bit per cycle, exactly 10 cycles, giving hundreds/tens/units. Leading zeros become space, except the units digit, which always shows. Examples: 0 -> "  0", 7 -> "  7", 42 -> " 42", 1023 -> "999". Then go to WIN.
- WIN: win_valid high, win_col/win_row = origin of the active requester. On win_valid && win_ready, go to PIX.
- PIX: counters row (0-7), chr (0-2), col (0-7), in row-major order. Pixel index = row*24 + chr*8 + col.
  - glyph_code = code of character chr; glyph_row = row.
  - pix_data = glyph_bits[col] ? FG_COLOR : BG_COLOR.
  - pix_last = (index == 191).
  - Counters advance only on pix_valid && pix_ready. The transfer at index 191 moves to DONE.
- DONE: done = 1 for one cycle, then IDLE. Requests are not sampled in DONE.
- Request lines deasserted before ack are simply not served; there is no abort after ack.

## Timing
- Reset values: all outputs 0 (acks, busy, win_valid, win_col, win_row, pix_valid, pix_data, pix_last, done, glyph_code, glyph_row). State IDLE, round-robin pointer = message.
- Reset asserted mid-operation: immediate return to IDLE with the above values. The partial window is abandoned; the driver must tolerate it.
- Message path: ack in cycle t; win_valid from t+1.
- Count path: ack in cycle t; CONV in t+1..t+10; win_valid from t+11.
- First pixel valid the cycle after the window handshake.
- With pix_ready held high: 192 consecutive pixel cycles, then done on the following cycle, then IDLE. Next ack is possible the cycle after DONE.
- While stalled (valid && !ready), win_col/win_row and pix_data/pix_last/glyph_code/glyph_row are held stable.
- Glyph ROM path is combinational within one cycle: glyph_code/glyph_row in -> glyph_bits -> pix_data.

## Test plan
- msg_req=1, msg_sel=0, ready lines high -> ack at t, win (MSG_COL, MSG_ROW) at t+1; row 0 pixels 0-7 follow G row 'h3C (BG,BG,FG,FG,FG,FG,BG,BG); pixels 16-23 all BG (space); pix_last on pixel 191; done one cycle after pixel 191.
- cnt_req with cnt_val=42 -> win at ack+11; glyph_code sequence per row {12,4,2}; cnt_val=0 -> {12,12,0}; cnt_val=1023 -> {9,9,9}.
- msg_req and cnt_req asserted together and held -> msg, cnt, msg, cnt served in turn; ack pulses never overlap.
- Random pix_ready/win_ready stalls (about 50%) -> exactly 192 pixels, no duplicates or drops, outputs stable during every stall, pixel order matches the row-major reference model.
- rst asserted at pixel 100 of an "ERS" draw -> all outputs 0 on the next cycle; after release a new msg_req is acked and drawn starting from pixel 0.
- msg_sel toggled after ack -> drawn string still matches the value sampled at ack.
